// File: rtl/lsram_ahb_ctrl_pkg.sv
// rtl/lsram_ahb_ctrl_pkg.sv - shared types, size codes and byte-enable decode for lsram_ahb_ctrl
// RMW states exist only when LSRAM_AHB_CTRL_SUBWORD_RMW_EN is defined.
package lsram_ahb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT
`ifdef LSRAM_AHB_CTRL_SUBWORD_RMW_EN
    ,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_RMW_WR
`endif
  } state_e;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Codes above SZ_WORD decode as a full word.
  function automatic logic [3:0] size_to_ben(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: size_to_ben = 4'b0001 << addr_lo;
      SZ_HALF: size_to_ben = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: size_to_ben = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsram_ahb_bytemerge.sv
// rtl/lsram_ahb_bytemerge.sv - per-lane merge of a new word into an old word under byte enables
// Used by lsram_ahb_ctrl only when LSRAM_AHB_CTRL_SUBWORD_RMW_EN is defined.
module lsram_ahb_bytemerge (
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  ben_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    for (int b = 0; b < 4; b++) begin
      if (ben_i[b]) merged_o[8*b +: 8] = new_word_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/lsram_ahb_ctrl.sv
// rtl/lsram_ahb_ctrl.sv - AHB SRAM command to LSRAM word strobes with read-latency tracking
// Define LSRAM_AHB_CTRL_SUBWORD_RMW_EN to turn byte/halfword writes into read-modify-write.
module lsram_ahb_ctrl
  import lsram_ahb_ctrl_pkg::*;
#(
  parameter int MEM_AWIDTH = 19,
  parameter int RD_LATENCY = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  ahbsram_req,
  input  logic                  ahbsram_write,
  input  logic [2:0]            ahbsram_size,
  input  logic [MEM_AWIDTH-1:0] ahbsram_addr_mem,
  input  logic [31:0]           ahbsram_wdata,
  output logic                  sramahb_ack,
  output logic [31:0]           sramahb_rdata,
  output logic                  BUSY,
  output logic [MEM_AWIDTH-3:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_ben,
  output logic                  ram_wen,
  output logic                  ram_ren,
  input  logic [31:0]           ram_rdata
);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("lsram_ahb_ctrl: RD_LATENCY out of range");
  end

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [MEM_AWIDTH-3:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [3:0]            ben_q, ben_d;
  logic                  wen_q, wen_d, ren_q, ren_d, ack_q, ack_d, busy_q, busy_d;
  logic [3:0]            req_ben;

  assign req_ben = size_to_ben(ahbsram_size, ahbsram_addr_mem[1:0]);

`ifdef LSRAM_AHB_CTRL_SUBWORD_RMW_EN
  logic [3:0]  cmd_ben_q, cmd_ben_d;
  logic [31:0] merged;

  lsram_ahb_bytemerge u_merge (
    .old_word_i(ram_rdata),
    .new_word_i(wdata_q),
    .ben_i     (cmd_ben_q),
    .merged_o  (merged)
  );
`endif

  // ram_rdata is sampled on the edge that opens the ack cycle, so the capture
  // happens one state early: in RD when the count is already 0, else at count 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ben_d   = 4'b0000;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    ack_d   = 1'b0;
`ifdef LSRAM_AHB_CTRL_SUBWORD_RMW_EN
    cmd_ben_d = cmd_ben_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ahbsram_req) begin
          addr_d  = ahbsram_addr_mem[MEM_AWIDTH-1:2];
          wdata_d = ahbsram_wdata;
          if (!ahbsram_write) begin
            state_d = ST_RD;
            ren_d   = 1'b1;
            ben_d   = 4'b1111;
            cnt_d   = LAT_INIT;
`ifdef LSRAM_AHB_CTRL_SUBWORD_RMW_EN
          end else if (req_ben != 4'b1111) begin
            state_d   = ST_RMW_RD;
            ren_d     = 1'b1;
            ben_d     = 4'b1111;
            cnt_d     = LAT_INIT;
            cmd_ben_d = req_ben;
`endif
          end else begin
            state_d = ST_WR;
            wen_d   = 1'b1;
            ben_d   = req_ben;
            ack_d   = 1'b1;
          end
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD: begin
        state_d = ST_RD_WAIT;
        if (cnt_q == 2'd0) begin
          ack_d   = 1'b1;
          rdata_d = ram_rdata;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            ack_d   = 1'b1;
            rdata_d = ram_rdata;
          end
        end
      end
`ifdef LSRAM_AHB_CTRL_SUBWORD_RMW_EN
      ST_RMW_RD: begin
        state_d = ST_RMW_WAIT;
        if (cnt_q == 2'd0) wdata_d = merged;
      end
      ST_RMW_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RMW_WR;
          wen_d   = 1'b1;
          ben_d   = 4'b1111;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) wdata_d = merged;
        end
      end
      ST_RMW_WR: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ben_q   <= 4'b0000;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ben_q   <= ben_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LSRAM_AHB_CTRL_SUBWORD_RMW_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) cmd_ben_q <= 4'b0000;
    else        cmd_ben_q <= cmd_ben_d;
  end
`endif

  assign sramahb_ack   = ack_q;
  assign sramahb_rdata = rdata_q;
  assign BUSY          = busy_q;
  assign ram_addr      = addr_q;
  assign ram_wdata     = wdata_q;
  assign ram_ben       = ben_q;
  assign ram_wen       = wen_q;
  assign ram_ren       = ren_q;

endmodule

// File: doc/lsram_ahb_ctrl.md
# lsram_ahb_ctrl

Memory-side controller between the AHB-Lite SRAM interface and the PolarFire LSRAM array. Consumes the single-cycle `ahbsram_req` command (write flag, size, byte address, write data) and turns it into word-addressed RAM strobes with byte enables. Tracks the RAM's synchronous read latency and returns `sramahb_ack` with `sramahb_rdata`. Drives `BUSY` while a command is in flight.

## Interface
- `MEM_AWIDTH`, 19: width of the byte address from the upstream interface.
- `RD_LATENCY`, 1: LSRAM read latency in cycles, from `ram_ren` to valid `ram_rdata`. Legal range 1..3.
- `HCLK` in 1: single clock; all logic is on its rising edge.
- `HRESET` in 1: reset, **synchronous, active-high**.
- `ahbsram_req` in 1: one-cycle command strobe.
- `ahbsram_write` in 1: 1 = write, 0 = read; valid with `ahbsram_req`.
- `ahbsram_size` in 3: 000 byte, 001 halfword, 010 word. Any code above 010 is treated as word.
- `ahbsram_addr_mem` in MEM_AWIDTH: byte address.
- `ahbsram_wdata` in 32: write data, already lane-placed; valid with `ahbsram_req`.
- `sramahb_ack` out 1: one-cycle completion pulse.
- `sramahb_rdata` out 32: read data; held until the next read completes.
- `BUSY` out 1: high whenever the state is not IDLE.
- `ram_addr` out MEM_AWIDTH-2: word address.
- `ram_wdata` out 32: RAM write data.
- `ram_ben` out 4: byte enables.
- `ram_wen` out 1: RAM write strobe.
- `ram_ren` out 1: RAM read strobe.
- `ram_rdata` in 32: RAM read data.

## Operation
- States: IDLE, WR, RD, RD_WAIT. With the macro defined, also RMW_RD, RMW_WAIT and RMW_WR.
- IDLE:
  - On `ahbsram_req`, register the word address (`addr[MEM_AWIDTH-1:2]`), byte enables, wdata and write flag.
  - Next state is WR for a write, RD for a read.
- A `ahbsram_req` outside IDLE is ignored; no state change and no ack.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Halfword: `addr[1] ? 1100 : 0011` (`addr[0]` ignored).
  - Word: 1111.
- WR: `ram_wen`=1 with the registered addr, wdata and ben; `sramahb_ack`=1; next state IDLE.
- RD: `ram_ren`=1 for one cycle, `ram_ben`=1111; load the latency counter with RD_LATENCY-1; next state RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: capture `ram_rdata` into `sramahb_rdata`, pulse ack, go to IDLE.
  - The captured value drives `sramahb_rdata` from the ack cycle onward.
- Outside their active state, `ram_wen` and `ram_ren` are 0 and `ram_ben` is 0000.
- `ram_addr` and `ram_wdata` hold their last registered value.

## Timing
- Command at cycle T.
- Write: `ram_wen` and ack at T+1. Next command accepted at T+2.
- Read: `ram_ren` at T+1. ack with valid rdata at T+1+RD_LATENCY.
- `BUSY` is high from T+1 through the ack cycle inclusive.
- Every output is driven from a register; there is no combinational path from input to output.
- Reset values: state IDLE, `sramahb_ack`=0, `BUSY`=0, `sramahb_rdata`=0, `ram_wen`=0, `ram_ren`=0, `ram_ben`=0, `ram_addr`=0, `ram_wdata`=0, counter 0.
- Reset mid-operation: abort on the next edge. No ack is issued and no further RAM strobe is issued. A write already strobed is not undone.
- A `ahbsram_req` in the same cycle as `HRESET` is dropped.

## Configuration
- `LSRAM_AHB_CTRL_SUBWORD_RMW_EN` defined:
  - Byte and halfword writes become read-modify-write, for RAM builds without byte enables.
  - Sequence: RMW_RD (`ram_ren`), RMW_WAIT (RD_LATENCY countdown), merge, then RMW_WR.
  - Merge rule: for each byte lane, ben=1 takes the new byte, otherwise the byte read from RAM.
  - RMW_WR: `ram_wen` with `ram_ben`=1111 and ack.
  - Sub-word write ack lands at T+2+RD_LATENCY.
  - `sramahb_rdata` is not updated by RMW.
  - Word writes are unchanged.
- Undefined: sub-word writes use byte enables directly, 1-cycle write path only. The RMW states are not compiled.

## Structure
- Package `lsram_ahb_ctrl_pkg`:
  - State encoding.
  - Size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
  - Function `size_to_ben(size, addr[1:0])`.
  - RD_LATENCY bounds.
- One sub-module, `lsram_ahb_bytemerge`: combinational lane merge (old word, new word, ben → merged word). Instantiated only under the macro.
- The counter and FSM stay in the top module.

## Test plan
- Word write, addr 0x00010, data 0xDEADBEEF:
  - T+1: `ram_wen`=1, `ram_addr`=0x4, ben=1111, ack=1.
  - A following read returns 0xDEADBEEF.
- Byte write, addr 0x3, data 0xAA000000:
  - ben=1000.
  - With the macro: RAM word 0x11223344 becomes 0xAA223344, ack at T+2+RD_LATENCY.
- Read with RD_LATENCY=2, 3 and 1:
  - RD_LATENCY=2: ack at exactly T+3.
  - `sramahb_rdata` is held through three idle cycles after the ack.
  - Repeat with RD_LATENCY=3 (ack at T+4) and RD_LATENCY=1 (ack at T+2).
- Halfword write at addr 0x6 → ben=1100. Size code 011 → ben=1111.
- Request while `BUSY` → ignored: exactly one ack, no extra strobes.
- `HRESET` during RD_WAIT → IDLE next cycle, no ack, rdata=0, `BUSY`=0. A new read after reset completes normally.
